i2s_tx: RTL

- I2S slave transmitter: serializes stereo PCM samples onto the codec DIN pin (ARDUINO_IO[2]).
- The codec is clock master and drives SCLK and LRCLK (ARDUINO_IO[5], ARDUINO_IO[4]). The block oversamples both with the 50 MHz system clock.
- Samples arrive on a valid/ready push interface (decoder or DMA side) and are buffered in an internal FIFO.
- This is the transmit counterpart of the codec's I2S data input.

---
 rtl/i2s_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: I2S slave transmitter. The codec drives SCLK/LRCLK, and stereo frames are queued in a FIFO.
// Build macro I2S_TX_HOLD_LAST_EN: on underrun, replay the last popped frame instead of sending zeros.
module i2s_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [2*DATA_W-1:0]         s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        sclk,
  input  logic                        lrclk,
  output logic                        sdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);

  // state       | meaning
  // ST_DISARMED | waiting for first SCLK fall after reset to capture LRCLK phase
  // ST_ARMED    | tracking channel starts and shifting bits out

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(DATA_W);

  typedef enum logic {ST_DISARMED, ST_ARMED} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sclk_sync_q;
  logic [1:0]          lr_sync_q;
  logic                lr_prev_q, lr_prev_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                s_ready_q, s_ready_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
`ifdef I2S_TX_HOLD_LAST_EN
  logic [2*DATA_W-1:0] last_q, last_d;
`endif

  logic                sclk_fall;
  logic                lr_now;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] rd_data;

  // lr_prev_q acts as the LRCLK edge-detect stage, sampled only on SCLK falls
  assign sclk_fall  = sclk_sync_q[2] & ~sclk_sync_q[1];
  assign lr_now     = lr_sync_q[1];
  assign push       = s_valid & s_ready_q;
  assign fifo_empty = (level_q == '0);
  assign rd_data    = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    lr_prev_d  = lr_prev_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
    last_d     = last_q;
`endif
    if (sclk_fall) begin
      case (state_q)
        ST_DISARMED: begin
          state_d   = ST_ARMED;
          lr_prev_d = lr_now;
        end
        ST_ARMED: begin
          if (lr_now != lr_prev_q) begin
            lr_prev_d = lr_now;
            bit_cnt_d = '0;
            if (!lr_now) begin
              if (enable && !fifo_empty) begin
                pop     = 1'b1;
                shift_d = rd_data[2*DATA_W-1:DATA_W];
                hold_d  = rd_data[DATA_W-1:0];
              end else if (enable) begin
                underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                shift_d    = last_q[2*DATA_W-1:DATA_W];
                hold_d     = last_q[DATA_W-1:0];
`else
                shift_d    = '0;
                hold_d     = '0;
`endif
              end else begin
                shift_d = '0;
                hold_d  = '0;
              end
            end else begin
              shift_d = hold_q;
            end
          end else if (bit_cnt_q < CNT_END) begin
            sdata_d   = shift_q[DATA_W-1];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            sdata_d = 1'b0;
          end
        end
      endcase
    end
`ifdef I2S_TX_HOLD_LAST_EN
    if (pop) last_d = rd_data;
`endif
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    s_ready_d = (level_d != LVL_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_DISARMED;
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      lr_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      level_q     <= '0;
      s_ready_q   <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef I2S_TX_HOLD_LAST_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      lr_sync_q   <= {lr_sync_q[0], lrclk};
      lr_prev_q   <= lr_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      level_q     <= level_d;
      s_ready_q   <= s_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef I2S_TX_HOLD_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

  // storage is not reset; flushing is done by the pointers and level
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= s_data;
  end

  assign sdata      = sdata_q;
  assign s_ready    = s_ready_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule
